mult_pipe: RTL
==============

# mult_pipe

Parametrised, fully pipelined RISC-V M-extension multiplier for the execute stage. Supports MUL/MULH/MULHSU/MULHU for XLEN 32 or 64, and MULW when XLEN=64. Adds a valid/stall/kill pipeline protocol and a pending-destination mask for hazard detection. Sits beside the ALU; its result feeds the writeback mux.

## Interface
- XLEN, 64: datapath width; legal values 32, 64.
- LATENCY, 4: cycles from accepted issue to `valid_o`; fixed at 4 in this generation; other values are a lint error.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  issue strobe for a multiply.
- opr_a_i  in  XLEN  multiplicand (rs1).
- opr_b_i  in  XLEN  multiplier (rs2).
- mult_func_i  in  3  cpu_consts encoding: MUL=000, MULH=001, MULHSU=010, MULHU=011.
- word_op_i  in  1  MULW; ignored when XLEN=32.
- rd_addr_i  in  5  destination register.
- stall_i  in  1  freeze the whole pipeline.
- kill_i  in  1  flush all in-flight and incoming operations.
- valid_o  out  1  result valid.
- mult_res_o  out  XLEN  result.
- rd_addr_o  out  5  destination of the result.
- rd_wr_en_o  out  1  `valid_o && rd_addr_o != 0`.
- busy_o  out  1  any stage, including the output stage, holds a valid op.
- pend_rd_mask_o  out  32  bit r set when any valid stage holds rd==r with r≠0; bit 0 is always 0.

## Operation
- S1 registers:
  - Operand magnitudes split into XLEN/2 halves.
  - Negate flag: signedness per func; a signed, b signed for MULH; a signed only for MULHSU; neither for MULHU; low-half result identical for MUL.
  - func, word_op, rd, valid.
- MULW:
  - Operands are bits [31:0], treated as signed; upper bits are ignored.
  - Result is the low 32 bits of the product, sign-extended to 64.
- word_op_i with a func other than MUL is executed as MULW.
- S2: four half-width partial products.
- S3: full 2·XLEN-bit sum, ((p1+p2)<<XLEN/2) + p0 + (p3<<XLEN).
- S4 (output register):
  - Two's-complement negate if the negate flag is set.
  - MUL/MULW select the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
  - Out-of-range func values yield 0, with the valid/write behaviour unchanged.
- Each stage carries a valid bit. Payload registers may hold stale data when their valid bit is 0.
- Stall (stall_i=1, kill_i=0):
  - No stage register changes; valid_i and the input operands are ignored.
  - All outputs hold their values.
  - Writeback consumes the result only in a cycle with stall_i=0.
- Kill (kill_i=1):
  - On the next edge, all stage valid bits including the output stage clear.
  - The same-cycle issue is discarded.
  - Kill has priority over stall and over valid_i.
- Reset: all valid bits 0. On the edge after reset, valid_o=0, rd_wr_en_o=0, busy_o=0, pend_rd_mask_o=0, mult_res_o=0 and rd_addr_o=0. Reset dominates kill and stall.
- pend_rd_mask_o and busy_o are combinational from the stage valid bits and rd registers. They include the output stage; they exclude the current-cycle input.

## Timing
- Accepted issue at edge N (valid_i=1, stall_i=0, kill_i=0) → valid_o=1 after edge N+3, i.e. the 4th register. Each stall cycle adds one cycle.
- Throughput is one op per cycle. Back-to-back issues produce back-to-back results in order.
- Bubbles propagate as valid=0 without modifying rd_wr_en_o.
- With stall_i=1, valid_o may remain 1 for multiple cycles with the same result.
- Simultaneous issue and kill: the issue is dropped and no result is ever produced.
- Reset asserted mid-operation flushes everything; the first issue after reset deasserts follows normal latency.

## Test plan
- **Basic multiplies (XLEN=64), each issued at cycle 0:**
  - MUL 7 × −3 → 0xFFFF_FFFF_FFFF_FFEB at cycle 4, rd_wr_en_o=1.
  - MULH 0x8000_0000_0000_0000 × same → 0x4000_0000_0000_0000.
  - MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- **MULW:** a=0xDEAD_BEEF_7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE. A second case with func=MULH and word_op=1 gives the same result.
- **Back-to-back:** 4 consecutive issues with rd=1,2,3,4 → valid_o on cycles 4–7 in order.
  - pend_rd_mask_o=0x1E at cycle 4.
  - An issue with rd=0 gives valid_o=1, rd_wr_en_o=0, and its mask bit stays 0.
- **Stall:** issue at cycle 0, stall_i high during cycles 2–3.
  - valid_o rises at cycle 6.
  - Stall again at cycle 6: output held unchanged with valid_o=1 until stall_i drops.
- **Kill:** issue at cycles 0–2, kill_i at cycle 2 together with a fourth issue, then a fresh issue at cycle 3.
  - No valid_o until cycle 7, which carries only the fresh op.
  - busy_o=0 in cycle 3.
- **Reset and XLEN=32:**
  - Synchronous reset asserted at cycle 2 of an in-flight op → no valid_o afterwards, all outputs 0.
  - XLEN=32 instance: MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE, word_op_i ignored.

Source files
------------

// File: rtl/mult_pipe_if.sv
// mult_pipe_if: issue/result bundle for the pipelined M-extension multiplier.
//   master : execute-stage side; drives the issue fields plus stall/kill and
//            observes the result, the busy flag and the pending-rd mask.
//   slave  : the multiplier itself.
// Signals:
//   valid_i, opr_a_i, opr_b_i, mult_func_i, word_op_i, rd_addr_i  issue fields
//   stall_i, kill_i                                                pipeline control
//   valid_o, mult_res_o, rd_addr_o, rd_wr_en_o                     writeback
//   busy_o, pend_rd_mask_o                                         hazard detection
interface mult_pipe_if #(
    parameter int unsigned XLEN = 64
);
    logic            valid_i;
    logic [XLEN-1:0] opr_a_i;
    logic [XLEN-1:0] opr_b_i;
    logic [2:0]      mult_func_i;
    logic            word_op_i;
    logic [4:0]      rd_addr_i;
    logic            stall_i;
    logic            kill_i;
    logic            valid_o;
    logic [XLEN-1:0] mult_res_o;
    logic [4:0]      rd_addr_o;
    logic            rd_wr_en_o;
    logic            busy_o;
    logic [31:0]     pend_rd_mask_o;

    modport master (
        output valid_i, opr_a_i, opr_b_i, mult_func_i, word_op_i, rd_addr_i,
        output stall_i, kill_i,
        input  valid_o, mult_res_o, rd_addr_o, rd_wr_en_o, busy_o, pend_rd_mask_o
    );

    modport slave (
        input  valid_i, opr_a_i, opr_b_i, mult_func_i, word_op_i, rd_addr_i,
        input  stall_i, kill_i,
        output valid_o, mult_res_o, rd_addr_o, rd_wr_en_o, busy_o, pend_rd_mask_o
    );
endinterface

// File: rtl/mult_pipe.sv
// mult_pipe: four-stage pipelined RISC-V multiplier (MUL/MULH/MULHSU/MULHU, MULW
// when XLEN=64) with valid/stall/kill control and a pending-destination mask.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    mult_pipe_if slave: issue fields, stall/kill, result, busy, rd mask
// Stages: S1 operand magnitudes + negate flag, S2 half-width partial products,
// S3 full-width sum, S4 sign fix-up and high/low select (output register).
module mult_pipe #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned LATENCY = 4
) (
    input logic        clk,
    input logic        reset,
    mult_pipe_if.slave bus
);

    localparam int unsigned Half = XLEN / 2;
    localparam int unsigned W2   = 2 * XLEN;

    if (LATENCY != 4) begin : g_bad_latency
        $error("mult_pipe: LATENCY must be 4");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("mult_pipe: XLEN must be 32 or 64");
    end

    // Which slice of the final product becomes the result.
    typedef enum logic [1:0] {
        SelLo,
        SelHi,
        SelWord,
        SelZero
    } sel_e;

    // ------------------------------------------------------------------
    // S1 input decode
    // ------------------------------------------------------------------
    logic            word_eff;
    logic [XLEN-1:0] a_op;
    logic [XLEN-1:0] b_op;
    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    sel_e            sel_in;

    always_comb begin
        word_eff = (XLEN == 64) && bus.word_op_i;
        a_op     = bus.opr_a_i;
        b_op     = bus.opr_b_i;
        a_sgn    = 1'b0;
        b_sgn    = 1'b0;
        sel_in   = SelZero;
        if (word_eff) begin
            // Any func with word_op set runs as MULW on sign-extended low words.
            a_op   = XLEN'(signed'(bus.opr_a_i[31:0]));
            b_op   = XLEN'(signed'(bus.opr_b_i[31:0]));
            a_sgn  = 1'b1;
            b_sgn  = 1'b1;
            sel_in = SelWord;
        end else begin
            case (bus.mult_func_i)
                3'b000: sel_in = SelLo;  // low half is signedness-independent
                3'b001: begin
                    a_sgn  = 1'b1;
                    b_sgn  = 1'b1;
                    sel_in = SelHi;
                end
                3'b010: begin
                    a_sgn  = 1'b1;
                    sel_in = SelHi;
                end
                3'b011: sel_in = SelHi;
                default: sel_in = SelZero;
            endcase
        end
        a_neg = a_sgn & a_op[XLEN-1];
        b_neg = b_sgn & b_op[XLEN-1];
        // Negating the most negative value yields itself, which is the correct
        // unsigned magnitude.
        a_mag = a_neg ? -a_op : a_op;
        b_mag = b_neg ? -b_op : b_op;
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic            s1_valid_q;
    logic [Half-1:0] s1_a_lo_q;
    logic [Half-1:0] s1_a_hi_q;
    logic [Half-1:0] s1_b_lo_q;
    logic [Half-1:0] s1_b_hi_q;
    logic            s1_neg_q;
    sel_e            s1_sel_q;
    logic [4:0]      s1_rd_q;

    logic            s2_valid_q;
    logic [XLEN-1:0] s2_p0_q;
    logic [XLEN-1:0] s2_p1_q;
    logic [XLEN-1:0] s2_p2_q;
    logic [XLEN-1:0] s2_p3_q;
    logic            s2_neg_q;
    sel_e            s2_sel_q;
    logic [4:0]      s2_rd_q;

    logic            s3_valid_q;
    logic [W2-1:0]   s3_sum_q;
    logic            s3_neg_q;
    sel_e            s3_sel_q;
    logic [4:0]      s3_rd_q;

    logic            s4_valid_q;
    logic [XLEN-1:0] s4_res_q;
    logic [4:0]      s4_rd_q;

    // ------------------------------------------------------------------
    // S2 partial products, S3 sum, S4 fix-up
    // ------------------------------------------------------------------
    logic [XLEN-1:0] p0_d;
    logic [XLEN-1:0] p1_d;
    logic [XLEN-1:0] p2_d;
    logic [XLEN-1:0] p3_d;
    logic [W2-1:0]   sum_d;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] res_d;

    always_comb begin
        p0_d = XLEN'(s1_a_lo_q) * XLEN'(s1_b_lo_q);
        p1_d = XLEN'(s1_a_hi_q) * XLEN'(s1_b_lo_q);
        p2_d = XLEN'(s1_a_lo_q) * XLEN'(s1_b_hi_q);
        p3_d = XLEN'(s1_a_hi_q) * XLEN'(s1_b_hi_q);
    end

    always_comb begin
        sum_d = ((W2'(s2_p1_q) + W2'(s2_p2_q)) << Half) + W2'(s2_p0_q)
              + (W2'(s2_p3_q) << XLEN);
    end

    always_comb begin
        prod = s3_neg_q ? -s3_sum_q : s3_sum_q;
        case (s3_sel_q)
            SelLo:   res_d = prod[XLEN-1:0];
            SelHi:   res_d = prod[W2-1:XLEN];
            SelWord: res_d = XLEN'(signed'(prod[31:0]));
            default: res_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline advance: reset > kill > stall > shift
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_lo_q  <= '0;
            s1_a_hi_q  <= '0;
            s1_b_lo_q  <= '0;
            s1_b_hi_q  <= '0;
            s1_neg_q   <= 1'b0;
            s1_sel_q   <= SelZero;
            s1_rd_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_p0_q    <= '0;
            s2_p1_q    <= '0;
            s2_p2_q    <= '0;
            s2_p3_q    <= '0;
            s2_neg_q   <= 1'b0;
            s2_sel_q   <= SelZero;
            s2_rd_q    <= '0;
            s3_valid_q <= 1'b0;
            s3_sum_q   <= '0;
            s3_neg_q   <= 1'b0;
            s3_sel_q   <= SelZero;
            s3_rd_q    <= '0;
            s4_valid_q <= 1'b0;
            s4_res_q   <= '0;
            s4_rd_q    <= '0;
        end else if (bus.kill_i) begin
            // Payloads may go stale; only the valid bits matter after a flush.
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s4_valid_q <= 1'b0;
        end else if (!bus.stall_i) begin
            s1_valid_q <= bus.valid_i;
            s1_a_lo_q  <= a_mag[Half-1:0];
            s1_a_hi_q  <= a_mag[XLEN-1:Half];
            s1_b_lo_q  <= b_mag[Half-1:0];
            s1_b_hi_q  <= b_mag[XLEN-1:Half];
            s1_neg_q   <= a_neg ^ b_neg;
            s1_sel_q   <= sel_in;
            s1_rd_q    <= bus.rd_addr_i;

            s2_valid_q <= s1_valid_q;
            s2_p0_q    <= p0_d;
            s2_p1_q    <= p1_d;
            s2_p2_q    <= p2_d;
            s2_p3_q    <= p3_d;
            s2_neg_q   <= s1_neg_q;
            s2_sel_q   <= s1_sel_q;
            s2_rd_q    <= s1_rd_q;

            s3_valid_q <= s2_valid_q;
            s3_sum_q   <= sum_d;
            s3_neg_q   <= s2_neg_q;
            s3_sel_q   <= s2_sel_q;
            s3_rd_q    <= s2_rd_q;

            s4_valid_q <= s3_valid_q;
            s4_res_q   <= res_d;
            s4_rd_q    <= s3_rd_q;
        end
    end

    // ------------------------------------------------------------------
    // Hazard view: every stage including the output register
    // ------------------------------------------------------------------
    logic [3:0]      stage_valid;
    logic [3:0][4:0] stage_rd;
    logic [31:0]     pend_mask;

    always_comb begin
        stage_valid = {s4_valid_q, s3_valid_q, s2_valid_q, s1_valid_q};
        stage_rd    = {s4_rd_q, s3_rd_q, s2_rd_q, s1_rd_q};
        pend_mask   = '0;
        for (int i = 0; i < 4; i++) begin
            if (stage_valid[i] && stage_rd[i] != 5'd0) begin
                pend_mask[stage_rd[i]] = 1'b1;
            end
        end
    end

    assign bus.valid_o        = s4_valid_q;
    assign bus.mult_res_o     = s4_res_q;
    assign bus.rd_addr_o      = s4_rd_q;
    assign bus.rd_wr_en_o     = s4_valid_q && (s4_rd_q != 5'd0);
    assign bus.busy_o         = |stage_valid;
    assign bus.pend_rd_mask_o = pend_mask;

endmodule
